// File: rtl/pri_encoder_pipe.sv
// pri_encoder_pipe
//   Registered N-to-log2(N) encoder with valid/ready handshake on both sides.
//   The mode is chosen per beat: strict one-hot check, MSB priority or LSB
//   priority. There is one output register stage and no skid buffer. A
//   saturating counter records strict-mode violations.
//
// Parameters
//   N   input vector width (>=2, power of two)
//   W   output code width, log2(N)
//   CW  error counter width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_data [N]         request vector
//   mode [2]            00 strict one-hot, 01/11 MSB priority, 10 LSB priority
//   out_valid/out_ready output handshake
//   out_code [W]        encoded index
//   out_hit             in_data had at least one bit set
//   out_err             strict-mode violation on this beat
//   clear_err           synchronous clear of err_count
//   err_count [CW]      saturating violation count
module pri_encoder_pipe #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_code,
  output logic          out_hit,
  output logic          out_err,
  input  logic          clear_err,
  output logic [CW-1:0] err_count
);

  typedef struct packed {
    logic [W-1:0] code;
    logic         hit;
    logic         err;
  } res_t;

  localparam logic [CW-1:0] CMAX = '1;

  logic [W-1:0] msb_idx, lsb_idx;
  logic         onehot;
  logic         acc;
  res_t         nxt;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // Scan upward for the MSB (last hit wins) and downward for the LSB.
  always_comb begin
    msb_idx = '0;
    lsb_idx = '0;
    for (int i = 0; i < N; i++)
      if (in_data[i]) msb_idx = W'(i);
    for (int i = N - 1; i >= 0; i--)
      if (in_data[i]) lsb_idx = W'(i);
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign onehot = (|in_data) && ~|(in_data & (in_data - N'(1)));

  always_comb begin
    nxt.hit  = |in_data;
    nxt.err  = 1'b0;
    nxt.code = msb_idx;
    case (mode)
      2'b00: begin
        if (onehot) begin
          nxt.code = lsb_idx;
        end else begin
          // A violating beat leaves the previous code in place.
          nxt.err  = 1'b1;
          nxt.code = out_code;
        end
      end
      2'b10:   nxt.code = lsb_idx;
      default: nxt.code = msb_idx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_hit   <= 1'b0;
      out_err   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_code  <= nxt.code;
      out_hit   <= nxt.hit;
      out_err   <= nxt.err;
    end else if (out_ready) begin
      // Drain: data fields keep their last values.
      out_valid <= 1'b0;
    end
  end

  // Clear wins over increment, but an erroring beat on the clear edge
  // still counts as the first new violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (clear_err)
      err_count <= (acc && nxt.err) ? CW'(1) : '0;
    else if (acc && nxt.err && err_count != CMAX)
      err_count <= err_count + CW'(1);
  end

endmodule

// File: tb/tb_pri_encoder_pipe.sv
module tb_pri_encoder_pipe;
  localparam int N  = 8;
  localparam int W  = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_code;
  logic          out_hit;
  logic          out_err;
  logic          clear_err = 1'b0;
  logic [CW-1:0] err_count;

  int tests = 0;
  int fails = 0;

  pri_encoder_pipe #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_hit(out_hit), .out_err(out_err),
    .clear_err(clear_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: results expressed with logarithms and popcounts.
  int m_valid, m_code, m_hit, m_err, m_cnt;
  localparam int CMAX = (1 << CW) - 1;

  always @(posedge clk or negedge rst_n) begin : model
    int d, code, err, acc;
    if (!rst_n) begin
      m_valid <= 0; m_code <= 0; m_hit <= 0; m_err <= 0; m_cnt <= 0;
    end else begin
      d    = int'(in_data);
      acc  = (in_valid && (!m_valid || out_ready)) ? 1 : 0;
      err  = 0;
      code = m_code;
      if (mode == 2'b00) begin
        if ($countones(in_data) == 1) code = $clog2(d);
        else err = 1;
      end else if (mode == 2'b10) begin
        code = (d == 0) ? 0 : $clog2(d & -d);
      end else begin
        code = (d == 0) ? 0 : $clog2(d + 1) - 1;
      end
      if (acc != 0) begin
        m_valid <= 1; m_code <= code; m_hit <= (d != 0) ? 1 : 0; m_err <= err;
      end else if (out_ready) begin
        m_valid <= 0;
      end
      if (clear_err)
        m_cnt <= (acc != 0 && err != 0) ? 1 : 0;
      else if (acc != 0 && err != 0)
        m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp out_valid", int'(out_valid), m_valid);
      chk("cmp in_ready",  int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
      chk("cmp out_code",  int'(out_code), m_code);
      chk("cmp out_hit",   int'(out_hit), m_hit);
      chk("cmp out_err",   int'(out_err), m_err);
      chk("cmp err_count", int'(err_count), m_cnt);
    end
  end

  // Inputs are applied just after a rising edge; step() lets the next edge
  // take them and returns with registered outputs settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] d, input logic [1:0] m);
    in_valid = 1'b1; in_data = d; mode = m;
    step();
  endtask

  initial begin
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset err_count", int'(err_count), 0);
    chk("reset out_code",  int'(out_code), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Strict sweep of every one-hot input.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      beat(N'(1) << i, 2'b00);
      chk("sweep code",  int'(out_code), i);
      chk("sweep valid", int'(out_valid), 1);
      chk("sweep err",   int'(out_err), 0);
    end
    chk("sweep cnt", int'(err_count), 0);

    // Strict violations keep the previous code.
    beat(8'h10, 2'b00); chk("viol pre code", int'(out_code), 4);
    beat(8'h00, 2'b00);
    chk("viol0 code", int'(out_code), 4); chk("viol0 err", int'(out_err), 1);
    chk("viol0 hit", int'(out_hit), 0);
    beat(8'h18, 2'b00);
    chk("viol2 code", int'(out_code), 4); chk("viol2 err", int'(out_err), 1);
    chk("viol2 hit", int'(out_hit), 1);   chk("viol cnt", int'(err_count), 2);

    // Priority modes on 0x5A (bits 1,3,4,6).
    beat(8'h5A, 2'b01); chk("msb code", int'(out_code), 6); chk("msb err", int'(out_err), 0);
    beat(8'h5A, 2'b10); chk("lsb code", int'(out_code), 1); chk("lsb err", int'(out_err), 0);
    beat(8'h5A, 2'b11); chk("m11 code", int'(out_code), 6); chk("m11 err", int'(out_err), 0);

    // Backpressure: held result stays put and input is refused.
    beat(8'h04, 2'b00); chk("bp code", int'(out_code), 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(8'h40, 2'b00);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp hold code", int'(out_code), 2);
    end
    out_ready = 1'b1; #1;
    chk("bp release ready", int'(in_ready), 1);
    step();
    chk("bp new code", int'(out_code), 6);

    // Drain with hold-last data.
    in_valid = 1'b0; step();
    chk("drain valid", int'(out_valid), 0);
    chk("drain code", int'(out_code), 6);

    // Saturation and clear.
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("clear cnt", int'(err_count), 0);
    for (int i = 0; i < 5; i++) begin
      beat(8'h00, 2'b00);
      chk("sat cnt", int'(err_count), (i < 3) ? i + 1 : 3);
    end
    in_valid = 1'b0; clear_err = 1'b1; step();
    chk("clear alone", int'(err_count), 0);
    beat(8'h03, 2'b00); clear_err = 1'b0;
    chk("clear+err", int'(err_count), 1);

    // Asynchronous reset while stalled.
    beat(8'h01, 2'b00);
    out_ready = 1'b0; in_valid = 1'b0; step();
    chk("stall valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", int'(out_valid), 0);
    chk("arst cnt", int'(err_count), 0);
    chk("arst code", int'(out_code), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    beat(8'h08, 2'b00);
    chk("post rst valid", int'(out_valid), 1);
    chk("post rst code", int'(out_code), 3);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      case ($urandom_range(0, 3))
        0: in_data = '0;
        1: in_data = N'(1) << $urandom_range(0, N - 1);
        2: in_data = N'($urandom);
        default: in_data = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      step();
    end

    in_valid = 1'b0; clear_err = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
